mario_motion: RTL

MARIO_MOTION -- requirements
Module: mario_motion

---
 rtl/mario_motion.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mario_motion.sv
// Player motion core: walk, jump and gravity for a single sprite, updated
// once per video frame. Keys are synchronized first. Esc toggles a pause
// that freezes all motion state.
module mario_motion #(
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 608,
  parameter int unsigned X_START   = 64,
  parameter int unsigned GROUND_Y  = 400,
  parameter int unsigned WALK_STEP = 2,
  parameter int unsigned JUMP_V    = 12,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned VMAX      = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [5:0] move_state,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       facing,
  output logic       airborne,
  output logic       crouch,
  output logic       paused,
  output logic [1:0] mstate
);

  typedef enum logic [1:0] {
    GROUND  = 2'b00,
    RISING  = 2'b01,
    FALLING = 2'b10
  } state_e;

  // Key bit positions within move_state.
  localparam int unsigned K_UP    = 0;
  localparam int unsigned K_LEFT  = 1;
  localparam int unsigned K_RIGHT = 2;
  localparam int unsigned K_DOWN  = 3;
  localparam int unsigned K_SPACE = 4;
  localparam int unsigned K_ESC   = 5;

  // Constants widened to the 11-bit working width so no compare can wrap.
  localparam logic [10:0] X_MIN_W  = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W  = 11'(X_MAX);
  localparam logic [10:0] STEP_W   = 11'(WALK_STEP);
  localparam logic [10:0] GROUND_W = 11'(GROUND_Y);
  localparam logic [10:0] GRAV_W   = 11'(GRAVITY);
  localparam logic [10:0] VMAX_W   = 11'(VMAX);
  localparam logic [9:0]  X_MIN_P  = 10'(X_MIN);
  localparam logic [9:0]  X_MAX_P  = 10'(X_MAX);
  localparam logic [9:0]  X_START_P = 10'(X_START);
  localparam logic [9:0]  GROUND_P = 10'(GROUND_Y);
  localparam logic [4:0]  JUMP_V_P = 5'(JUMP_V);
  localparam logic [4:0]  GRAV_P   = 5'(GRAVITY);

  logic [5:0] ks_meta_q;
  logic [5:0] ks_q;
  logic       esc_prev_q;
  logic       paused_q,     paused_d;
  logic       jump_armed_q, jump_armed_d;
  logic [9:0] pos_x_q,      pos_x_d;
  logic [9:0] pos_y_q,      pos_y_d;
  logic [4:0] vy_q,         vy_d;
  logic       facing_q,     facing_d;
  state_e     state_q,      state_d;

  logic        esc_rise;
  logic        upd;
  logic        jump;
  logic        go_left;
  logic        go_right;
  logic        hold_x;
  logic [10:0] x_cur;
  logic [10:0] x_inc;
  logic [10:0] y_cur;
  logic [10:0] vy_cur;
  logic [10:0] vn_raw;
  logic [10:0] vn;
  logic [10:0] y_fall;

  assign esc_rise = ks_q[K_ESC] & ~esc_prev_q;
  // An esc edge coinciding with a frame tick wins: motion skips that frame.
  assign upd      = frame_tick & ~paused_q & ~esc_rise;
  assign jump     = ks_q[K_UP] | ks_q[K_SPACE];
  assign go_left  = ks_q[K_LEFT] & ~ks_q[K_RIGHT];
  assign go_right = ks_q[K_RIGHT] & ~ks_q[K_LEFT];
  assign hold_x   = (state_q == GROUND) & ks_q[K_DOWN];

  assign x_cur  = {1'b0, pos_x_q};
  assign x_inc  = x_cur + STEP_W;
  assign y_cur  = {1'b0, pos_y_q};
  assign vy_cur = {6'b0, vy_q};
  assign vn_raw = vy_cur + GRAV_W;
  assign vn     = (vn_raw > VMAX_W) ? VMAX_W : vn_raw;
  assign y_fall = y_cur + vn;

  // Next-state computation for pause, jump arming, horizontal and vertical motion.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    paused_d     = paused_q ^ esc_rise;
    jump_armed_d = jump_armed_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    vy_d         = vy_q;
    facing_d     = facing_q;
    state_d      = state_q;

    if (upd) begin
      if (!jump) jump_armed_d = 1'b1;

      // Horizontal: facing always follows a single direction key; motion
      // is suppressed while crouching on the ground.
      if (go_left) begin
        facing_d = 1'b0;
        if (!hold_x) begin
          if (x_cur < X_MIN_W + STEP_W) pos_x_d = X_MIN_P;
          else                          pos_x_d = 10'(x_cur - STEP_W);
        end
      end else if (go_right) begin
        facing_d = 1'b1;
        if (!hold_x) begin
          if (x_inc > X_MAX_W) pos_x_d = X_MAX_P;
          else                 pos_x_d = 10'(x_inc);
        end
      end

      // Vertical: launch, decelerate while rising, accelerate while falling.
      unique case (state_q)
        GROUND: begin
          if (jump && jump_armed_q) begin
            vy_d         = JUMP_V_P;
            state_d      = RISING;
            jump_armed_d = 1'b0;
          end
        end
        RISING: begin
          if (vy_cur > y_cur) begin
            pos_y_d = '0;
            vy_d    = '0;
            state_d = FALLING;
          end else begin
            pos_y_d = 10'(y_cur - vy_cur);
            if (vy_cur <= GRAV_W) begin
              vy_d    = '0;
              state_d = FALLING;
            end else begin
              vy_d = vy_q - GRAV_P;
            end
          end
        end
        FALLING: begin
          if (y_fall >= GROUND_W) begin
            pos_y_d = GROUND_P;
            vy_d    = '0;
            state_d = GROUND;
          end else begin
            pos_y_d = 10'(y_fall);
            vy_d    = 5'(vn);
          end
        end
        default: begin
          pos_y_d = GROUND_P;
          vy_d    = '0;
          state_d = GROUND;
        end
      endcase
    end
  end

  // Key synchronizer, esc edge detector and all motion state registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      ks_meta_q    <= '0;
      ks_q         <= '0;
      esc_prev_q   <= 1'b0;
      paused_q     <= 1'b0;
      jump_armed_q <= 1'b1;
      pos_x_q      <= X_START_P;
      pos_y_q      <= GROUND_P;
      vy_q         <= '0;
      facing_q     <= 1'b1;
      state_q      <= GROUND;
    end else begin
      ks_meta_q    <= move_state;
      ks_q         <= ks_meta_q;
      esc_prev_q   <= ks_q[K_ESC];
      paused_q     <= paused_d;
      jump_armed_q <= jump_armed_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      vy_q         <= vy_d;
      facing_q     <= facing_d;
      state_q      <= state_d;
    end
  end

  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign facing   = facing_q;
  assign paused   = paused_q;
  assign mstate   = state_q;
  assign airborne = (state_q != GROUND);
  assign crouch   = ks_q[K_DOWN] & (state_q == GROUND);

endmodule
